// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types: FSM states, NOP encoding, fetch packet
package core_pkg;

  localparam int PKT_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PKT_XLEN-1:0] pc;
    logic [31:0]         instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of fetch packets with flush
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  input  logic       push,
  input  fetch_pkt_t push_data,
  input  logic       pop,
  output fetch_pkt_t head,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty FIFO presents a NOP at pc 0 so decode never sees stale storage.
  assign head = empty ? '{pc: '0, instr: NOP_INSTR} : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V IF stage with prefetch FIFO and redirect flush (option: IFU_PERF_CNT_EN)
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, target, rsp_pc;
  logic [CW-1:0]   inflight, inflight_nxt, drop, drop_nxt, fifo_count;
  logic [CW:0]     occupancy;
  logic            req_hs, rsp_live, drop_hit, dec_hs;
  logic            fifo_flush, fifo_push, fifo_full, fifo_empty;
  fetch_pkt_t      push_pkt, head_pkt;

  assign target    = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};

  assign imem_req_valid = (state == RUN) && !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (inflight != '0);
  assign drop_hit       = imem_rsp_valid && (drop != '0);
  assign dec_hs         = id_valid && id_ready;

  // Requests since the last redirect are contiguous, so the oldest one sits inflight words behind pc.
  assign rsp_pc   = pc - (XLEN'(inflight) << 2);
  assign push_pkt = '{pc: rsp_pc, instr: imem_rsp_data};

  assign id_valid = !fifo_empty;
  assign id_instr = head_pkt.instr;
  assign id_pc    = head_pkt.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_pkt),
    .pop       (dec_hs),
    .head      (head_pkt),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state: redirect wins; stale responses already in the memory pipe become drops.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    inflight_nxt = inflight;
    drop_nxt     = drop;
    fifo_flush   = 1'b0;
    fifo_push    = 1'b0;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
        if (redirect_valid) pc_nxt = target;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_nxt       = target;
          fifo_flush   = 1'b1;
          inflight_nxt = '0;
          drop_nxt     = inflight + CW'(req_hs) - CW'(rsp_live);
          state_nxt    = (drop_nxt != '0) ? FLUSH : RUN;
        end else begin
          if (req_hs) pc_nxt = pc + XLEN'(4);
          fifo_push    = rsp_live;
          inflight_nxt = inflight + CW'(req_hs) - CW'(rsp_live);
        end
      end
      FLUSH: begin
        if (drop_hit)       drop_nxt = drop - 1'b1;
        if (redirect_valid) pc_nxt   = target;
        if (drop_nxt == '0) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and outstanding-request counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating counters of delivered instructions and redirects.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (dec_hs && (perf_fetch_cnt != '1))         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100;
  int req_hs_cnt = 0, dec_hs_cnt = 0;
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  logic [31:0] exp_id_pc = RESET_PC;
  logic [31:0] exp_req_addr = RESET_PC;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Instruction memory: in-order responses, random latency, one response per cycle.
  initial begin
    int due;
    int last_due;
    last_due = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pend_due.delete();
        pend_addr.delete();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        last_due = 0;
      end else begin
        imem_req_ready = ($urandom_range(99) < ready_pct);
        if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr[0]);
          void'(pend_due.pop_front());
          void'(pend_addr.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = $urandom;
        end
      end
      #1;
      if (resetn && imem_req_valid && imem_req_ready) begin
        due = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_due.push_back(due);
        pend_addr.push_back(imem_req_addr);
        req_hs_cnt++;
      end
    end
  end

  // Reference model: fetch addresses and the decode stream are each a sequential run from the last target.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        exp_id_pc    = RESET_PC;
        exp_req_addr = RESET_PC;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          tests_run++;
          if (imem_req_addr !== exp_req_addr) begin
            tests_failed++;
            $display("FAIL req_addr: got %h expected %h (t=%0t)", imem_req_addr, exp_req_addr, $time);
          end
          exp_req_addr = exp_req_addr + 32'd4;
        end
        if (id_valid && id_ready) begin
          tests_run++;
          if (id_pc !== exp_id_pc || id_instr !== mem_word(exp_id_pc)) begin
            tests_failed++;
            $display("FAIL id_stream: got pc=%h instr=%h expected pc=%h instr=%h (t=%0t)",
                     id_pc, id_instr, exp_id_pc, mem_word(exp_id_pc), $time);
          end
          exp_id_pc = exp_id_pc + 32'd4;
          dec_hs_cnt++;
        end
        if (redirect_valid) begin
          exp_id_pc    = redirect_pc & 32'hFFFF_FFFC;
          exp_req_addr = redirect_pc & 32'hFFFF_FFFC;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #3;
    resetn = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    tests_run++;
    if (imem_req_addr !== RESET_PC) begin tests_failed++; $display("FAIL rst_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
    tests_run++;
    if (id_instr !== NOP_INSTR) begin tests_failed++; $display("FAIL rst_id_instr: got %h expected %h", id_instr, NOP_INSTR); end
    tests_run++;
    if (id_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_id_pc: got %h expected 0", id_pc); end
    @(negedge clk);
    #3;
    resetn = 1'b1;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL boot_no_req: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_k;
    first_k = -1;
    lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 10 && first_k < 0; k++) begin
      @(negedge clk);
      if (id_valid) first_k = k;
    end
    tests_run++;
    if (first_k != 3) begin tests_failed++; $display("FAIL first_valid_cycle: got %0d expected 3", first_k); end
    tests_run++;
    if (id_pc !== 32'h0) begin tests_failed++; $display("FAIL stream_pc0: got %h expected 0", id_pc); end
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      tests_run++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * j)) begin
        tests_failed++;
        $display("FAIL stream_pc%0d: got valid=%b pc=%h expected valid=1 pc=%h", j, id_valid, id_pc, 32'(4 * j));
      end
    end
  endtask

  task automatic test_stall();
    int start;
    lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b0;
    do_reset();
    start = req_hs_cnt;
    repeat (20) @(negedge clk);
    #2;
    tests_run++;
    if (req_hs_cnt - start != 4) begin tests_failed++; $display("FAIL stall_req_count: got %0d expected 4", req_hs_cnt - start); end
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL stall_head: got valid=%b pc=%h expected valid=1 pc=0", id_valid, id_pc);
    end
  endtask

  task automatic test_redirect_flush();
    bit seen;
    seen = 1'b0;
    lat_min = 3; lat_max = 3; ready_pct = 100; id_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    for (int n = 4; n <= 7; n++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      tests_run++;
      if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_stale_n%0d: got id_valid=%b expected 0", n, id_valid); end
      tests_run++;
      if (n < 7 && imem_req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_no_req_n%0d: got %b expected 0", n, imem_req_valid);
      end else if (n == 7 && (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)) begin
        tests_failed++;
        $display("FAIL flush_resume: got valid=%b addr=%h expected valid=1 addr=00000100", imem_req_valid, imem_req_addr);
      end
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = id_valid;
    end
    tests_run++;
    if (!seen || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin
      tests_failed++;
      $display("FAIL flush_target: got seen=%b pc=%h expected pc=00000100", seen, id_pc);
    end
  endtask

  task automatic test_redirect_collide();
    bit seen;
    seen = 1'b0;
    lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    #1;
    tests_run++;
    if (!(imem_req_valid && imem_req_ready && imem_rsp_valid)) begin
      tests_failed++;
      $display("FAIL collide_setup: got req=%b rdy=%b rsp=%b expected all 1", imem_req_valid, imem_req_ready, imem_rsp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF6;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_flush: got req_valid=%b expected 0", imem_req_valid); end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = id_valid;
    end
    tests_run++;
    if (!seen || id_pc !== 32'hFFFF_FFF4) begin
      tests_failed++;
      $display("FAIL collide_target: got seen=%b pc=%h expected pc=fffffff4", seen, id_pc);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_wrap: got valid=%b pc=%h expected valid=1 pc=0", id_valid, id_pc);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    tests_run++;
    if (id_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_setup: got id_valid=%b expected 1", id_valid); end
    #3;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got id_valid=%b req_valid=%b expected 0 0", id_valid, imem_req_valid);
    end
    repeat (2) @(negedge clk);
    #3;
    resetn = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL midrst_refetch: got valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = id_valid;
    end
    tests_run++;
    if (!seen || id_pc !== RESET_PC) begin
      tests_failed++;
      $display("FAIL midrst_first_pc: got seen=%b pc=%h expected pc=%h", seen, id_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    int start_dec;
    lat_min = 1; lat_max = 4; ready_pct = 70; id_ready = 1'b1;
    do_reset();
    start_dec = dec_hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      id_ready = ($urandom_range(99) < 75);
      if (i > 2 && $urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (dec_hs_cnt - start_dec < 200) begin
      tests_failed++;
      $display("FAIL random_progress: got %0d delivered expected at least 200", dec_hs_cnt - start_dec);
    end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    int base;
    lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b0;
    do_reset();
    base = dec_hs_cnt;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      id_ready       = (dec_hs_cnt - base < 10);
      redirect_valid = (i == 5 || i == 20);
      redirect_pc    = 32'h200 + 32'(i * 16);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    tests_run++;
    if (perf_fetch_cnt !== 32'd10) begin tests_failed++; $display("FAIL perf_fetch: got %0d expected 10", perf_fetch_cnt); end
    tests_run++;
    if (perf_flush_cnt !== 32'd2) begin tests_failed++; $display("FAIL perf_flush: got %0d expected 2", perf_flush_cnt); end
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_collide();
    test_reset_mid();
    test_random();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
